pll_lock_supervisor: RTL

Parametrised reset-and-lock sequencer placed beside each PLL wrapper in the clocking subsystem. It drives the PLL reset and waits for a stable lock, with timeout and bounded retries. It then releases per-output-clock domain resets in a staggered order and re-sequences automatically on lock loss. It generalises the fixed single-output PLL instance to N output channels with supervised bring-up.

---
 rtl/pll_sup_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 22 ++
 rtl/pll_lock_supervisor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Optional loss counter: define PLL_SUP_LOSS_COUNT_EN.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_WAIT = 3'd2,
    S_REL  = 3'd3,
    S_RUN  = 3'd4,
    S_FAIL = 3'd5
  } state_t;

  localparam int LOSS_W = 8;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Async active-low reset clears both flops.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer with staggered channel reset release.
// Optional loss counter: define PLL_SUP_LOSS_COUNT_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int STAGGER_CYCLES = 8,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic                             pll_locked,
  output logic                             pll_rst,
  output logic [NUM_CH-1:0]                ch_rst_n,
  output logic                             ready,
  output logic                             fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
  output logic [LOSS_W-1:0]                loss_cnt,
  output logic [2:0]                       state
);

  localparam int CW = cnt_width(RST_CYCLES, STABLE_CYCLES,
                                TIMEOUT_CYCLES, STAGGER_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STG_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] STB      = CW'(STABLE_CYCLES);
  localparam logic [RW-1:0] RMAX     = RW'(MAX_RETRIES);
  localparam logic [RW-1:0] RLAST    = RW'(MAX_RETRIES - 1);

  logic locked_s;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (locked_s)
  );

  state_t            st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     stab_q, stab_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [NUM_CH-1:0] ch_q, ch_d;
  logic              pll_rst_q, pll_rst_d;
  logic              ready_q, ready_d;
  logic              fail_q, fail_d;

  always_comb begin
    st_d      = st_q;
    cnt_d     = '0;
    stab_d    = '0;
    retry_d   = retry_q;
    ch_d      = '0;
    pll_rst_d = 1'b0;
    ready_d   = 1'b0;
    fail_d    = 1'b0;
    if (!enable) begin
      st_d = S_IDLE;
    end else begin
      unique case (st_q)
        S_IDLE: st_d = S_RST;
        S_RST: begin
          if (cnt_q == RST_LAST) st_d = S_WAIT;
          else cnt_d = cnt_q + 1'b1;
        end
        S_WAIT: begin
          stab_d = locked_s ? stab_q + 1'b1 : '0;
          if (stab_d == STB) begin
            st_d = S_REL;
          end else if (cnt_q == TO_LAST) begin
            st_d = (retry_q >= RLAST) ? S_FAIL : S_RST;
            if (retry_q != RMAX) retry_d = retry_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_REL: begin
          // a lock loss wins over any release due this cycle
          if (!locked_s) begin
            st_d = S_RST;
          end else if (&ch_q) begin
            st_d    = S_RUN;
            retry_d = '0;
            ch_d    = ch_q;
          end else if (cnt_q == STG_LAST) begin
            ch_d = NUM_CH'({ch_q, 1'b1});
          end else begin
            ch_d  = ch_q;
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!locked_s) st_d = S_RST;
          else ch_d = ch_q;
        end
        S_FAIL: st_d = S_FAIL;
        default: st_d = S_IDLE;
      endcase
    end
    unique case (1'b1)
      st_d == S_IDLE,
      st_d == S_RST: pll_rst_d = 1'b1;
      st_d == S_FAIL: begin
        pll_rst_d = 1'b1;
        fail_d    = 1'b1;
      end
      st_d == S_RUN: ready_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= S_IDLE;
      cnt_q     <= '0;
      stab_q    <= '0;
      retry_q   <= '0;
      ch_q      <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      stab_q    <= stab_d;
      retry_q   <= retry_d;
      ch_q      <= ch_d;
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

`ifdef PLL_SUP_LOSS_COUNT_EN
  logic [LOSS_W-1:0] loss_q;
  logic              loss_ev;

  assign loss_ev = enable && !locked_s &&
                   (st_q == S_REL || st_q == S_RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) loss_q <= '0;
    else if (loss_ev && loss_q != '1) loss_q <= loss_q + 1'b1;
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = '0;
`endif

  assign pll_rst   = pll_rst_q;
  assign ch_rst_n  = ch_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign state     = st_q;

endmodule
